// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the I-cache, D-cache and main-memory sides of the shared
//   memory port so the arbiter and its environment connect through one
//   object.
//   - slave  : arbiter view (takes cache requests and memory responses,
//              drives Ready/RData/Mem* and Owner)
//   - master : environment view (caches + memory model)
//   ADDR_W / DATA_W set the address and data widths of every bus signal.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // I-cache side
    logic              IReq;
    logic              IWE;
    logic [ADDR_W-1:0] IAddr;
    logic [DATA_W-1:0] IWData;
    logic              IReady;
    // D-cache side
    logic              DReq;
    logic              DWE;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWData;
    logic              DReady;
    // Read data broadcast to both caches
    logic [DATA_W-1:0] RData;
    // Memory side
    logic              MemReq;
    logic              MemWE;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
    logic              MemReady;
    // Current grant: 00 idle, 01 I-cache, 10 D-cache
    logic [1:0]        Owner;

    modport slave (
        input  IReq, IWE, IAddr, IWData,
        input  DReq, DWE, DAddr, DWData,
        input  MemRData, MemReady,
        output IReady, DReady, RData,
        output MemReq, MemWE, MemAddr, MemWData,
        output Owner
    );

    modport master (
        output IReq, IWE, IAddr, IWData,
        output DReq, DWE, DAddr, DWData,
        output MemRData, MemReady,
        input  IReady, DReady, RData,
        input  MemReq, MemWE, MemAddr, MemWData,
        input  Owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single main-memory port between the I-cache and D-cache
//   controllers. A requester that wins arbitration owns the port for one
//   block burst of BURST_LEN accepted beats, after which the port returns
//   to IDLE for one cycle and is re-arbitrated round-robin.
// Ports
//   CLK    : clock, all state on posedge
//   Reset  : synchronous, active-high
//   bus    : mem_port_arbiter_if.slave -- cache request/ready pairs,
//            memory beat interface, broadcast RData and Owner
// Parameters
//   BURST_LEN : beats per grant (words per cache block, >= 2)
module mem_port_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic                   CLK,
    input  logic                   Reset,
    mem_port_arbiter_if.slave      bus
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    // State encoding doubles as the Owner output code.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10
    } state_t;

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } last_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    last_t            last_owner_q, last_owner_d;

    logic  own_req;     // request line of the current owner
    last_t cur_owner;   // current owner expressed as a LastOwner value

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_owner_q <= LAST_I;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        own_req   = 1'b0;
        cur_owner = LAST_I;
        case (state_q)
            OWN_I: begin
                own_req   = bus.IReq;
                cur_owner = LAST_I;
            end
            OWN_D: begin
                own_req   = bus.DReq;
                cur_owner = LAST_D;
            end
            default: begin
                own_req   = 1'b0;
                cur_owner = LAST_I;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                // On a tie, the requester that did not own the port last wins.
                if (bus.IReq && bus.DReq) begin
                    state_d = (last_owner_q == LAST_I) ? OWN_D : OWN_I;
                end else if (bus.IReq) begin
                    state_d = OWN_I;
                end else if (bus.DReq) begin
                    state_d = OWN_D;
                end
            end
            OWN_I, OWN_D: begin
                if (!own_req) begin
                    // Dropped before any beat: a cache hit resolved, nothing
                    // moved, so the round-robin pointer is left alone. Dropped
                    // mid-burst: the grant counts as used.
                    state_d = IDLE;
                    if (cnt_q != '0) begin
                        cnt_d        = '0;
                        last_owner_d = cur_owner;
                    end
                end else if (bus.MemReady) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d        = '0;
                        last_owner_d = cur_owner;
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: everything follows the registered state, with the
    // owner's request/write/address/data muxed straight through.
    always_comb begin
        bus.MemReq   = 1'b0;
        bus.MemWE    = 1'b0;
        bus.MemAddr  = '0;
        bus.MemWData = '0;
        bus.IReady   = 1'b0;
        bus.DReady   = 1'b0;
        bus.Owner    = state_q;
        case (state_q)
            OWN_I: begin
                bus.MemReq   = bus.IReq;
                bus.MemWE    = bus.IWE;
                bus.MemAddr  = bus.IAddr;
                bus.MemWData = bus.IWData;
                bus.IReady   = bus.MemReady & bus.IReq;
            end
            OWN_D: begin
                bus.MemReq   = bus.DReq;
                bus.MemWE    = bus.DWE;
                bus.MemAddr  = bus.DAddr;
                bus.MemWData = bus.DWData;
                bus.DReady   = bus.MemReady & bus.DReq;
            end
            default: begin
                bus.Owner = 2'b00;
            end
        endcase
    end

    assign bus.RData = bus.MemRData;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int BL = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.BURST_LEN(BL)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 none, 1 I, 2 D.  beats: beats accepted in the current grant.
    int m_owner = 0;
    int m_beats = 0;
    int m_last  = 1;

    always @(negedge clk) begin : model
        logic        e_req, e_we, e_ir, e_dr;
        logic [31:0] e_addr, e_wd;
        e_req = 1'b0; e_we = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
        e_addr = '0; e_wd = '0;
        if (m_owner == 1) begin
            e_req = bus.IReq; e_we = bus.IWE; e_addr = bus.IAddr; e_wd = bus.IWData;
            e_ir  = bus.IReq & bus.MemReady;
        end else if (m_owner == 2) begin
            e_req = bus.DReq; e_we = bus.DWE; e_addr = bus.DAddr; e_wd = bus.DWData;
            e_dr  = bus.DReq & bus.MemReady;
        end
        chk("owner",  bus.Owner,  m_owner[1:0]);
        chk("memreq", bus.MemReq, e_req);
        chk("memwe",  bus.MemWE,  e_we);
        chk("iready", bus.IReady, e_ir);
        chk("dready", bus.DReady, e_dr);
        chk("rdata",  bus.RData,  bus.MemRData);
        if (m_owner != 0) begin
            chk("memaddr",  bus.MemAddr,  e_addr);
            chk("memwdata", bus.MemWData, e_wd);
        end

        if (rst) begin
            m_owner = 0; m_beats = 0; m_last = 1;
        end else if (m_owner == 0) begin
            if (bus.IReq && bus.DReq) m_owner = (m_last == 1) ? 2 : 1;
            else if (bus.IReq)        m_owner = 1;
            else if (bus.DReq)        m_owner = 2;
        end else if (!e_req) begin
            if (m_beats != 0) begin
                $display("grant %s abandoned after %0d beats", (m_owner == 1) ? "I" : "D", m_beats);
                m_last  = m_owner;
                m_beats = 0;
            end
            m_owner = 0;
        end else if (bus.MemReady) begin
            m_beats++;
            if (m_beats == BL) begin
                $display("grant %s burst done (%0d beats)", (m_owner == 1) ? "I" : "D", BL);
                m_beats = 0;
                m_last  = m_owner;
                m_owner = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.IReq = 0; bus.IWE = 0; bus.IAddr = '0; bus.IWData = '0;
        bus.DReq = 0; bus.DWE = 0; bus.DAddr = '0; bus.DWData = '0;
        bus.MemReady = 0; bus.MemRData = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int t2_owner(input int c);
        if (c == 0 || c == 5 || c == 10) return 0;
        if (c >= 6 && c <= 9)            return 1;
        return 2;
    endfunction

    function automatic int t4_owner(input int c);
        if (c == 0 || c == 5 || c == 10) return 0;
        if (c >= 6 && c <= 9)            return 1;
        return 2;
    endfunction

    initial begin
        int rcount;
        rst = 1'b1;
        idle_inputs();

        // 1: I alone, MemReady every cycle
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            bus.IReq = 1; bus.MemReady = 1;
            bus.IAddr = 32'h100 + c * 4;
            bus.MemRData = $urandom;
            #1;
            if (c == 0) begin
                chk("t1_owner_c0", bus.Owner, 0);
                chk("t1_memreq_c0", bus.MemReq, 0);
            end else if (c <= 4) begin
                chk("t1_owner",  bus.Owner,   1);
                chk("t1_iready", bus.IReady,  1);
                chk("t1_addr",   bus.MemAddr, 32'h100 + c * 4);
            end else begin
                chk("t1_owner_c5", bus.Owner, 0);
            end
            tick();
        end

        // 2: both rise together -> D, I, D alternation
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            bus.IReq = 1; bus.DReq = 1; bus.MemReady = 1;
            #1;
            chk("t2_owner", bus.Owner, t2_owner(c));
            tick();
        end

        // 3: D rises during I beat 2
        do_reset();
        bus.IAddr = 32'h1000; bus.DAddr = 32'h2000;
        for (int c = 0; c <= 6; c++) begin
            bus.IReq = 1; bus.MemReady = 1;
            if (c >= 2) bus.DReq = 1;
            #1;
            if (c >= 1 && c <= 4) begin
                chk("t3_owner_i", bus.Owner, 1);
                chk("t3_addr_i", bus.MemAddr, 32'h1000);
            end
            if (c <= 5) chk("t3_dready0", bus.DReady, 0);
            if (c == 5) chk("t3_owner_gap", bus.Owner, 0);
            if (c == 6) begin
                chk("t3_owner_d", bus.Owner, 2);
                chk("t3_dready1", bus.DReady, 1);
                chk("t3_addr_d", bus.MemAddr, 32'h2000);
            end
            tick();
        end

        // 4: D writeback + refill with I pending
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            bus.IReq = 1; bus.DReq = 1; bus.MemReady = 1;
            bus.DWE = (c <= 4);
            #1;
            chk("t4_owner", bus.Owner, t4_owner(c));
            if (c >= 1 && c <= 4)   chk("t4_we_wb", bus.MemWE, 1);
            if (c >= 11 && c <= 14) chk("t4_we_rf", bus.MemWE, 0);
            tick();
        end

        // 5: MemReady stall mid-burst
        do_reset();
        rcount = 0;
        for (int c = 0; c <= 8; c++) begin
            bus.IReq = 1;
            bus.MemReady = !(c >= 2 && c <= 4);
            #1;
            if (bus.IReady) rcount++;
            if (c >= 2 && c <= 4) begin
                chk("t5_stall_iready", bus.IReady, 0);
                chk("t5_stall_owner",  bus.Owner,  1);
            end
            if (c == 7) chk("t5_owner_c7", bus.Owner, 1);
            if (c == 8) chk("t5_owner_c8", bus.Owner, 0);
            tick();
        end
        chk("t5_beats", rcount, 4);

        // 6: Reset during D beat 3
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            bus.MemReady = 1;
            bus.DReq = (c <= 3);
            bus.IReq = (c >= 4);
            rst = (c == 3);
            #1;
            if (c == 3) chk("t6_owner_c3", bus.Owner, 2);
            if (c == 4) begin
                chk("t6_owner_c4",  bus.Owner,  0);
                chk("t6_memreq_c4", bus.MemReq, 0);
            end
            if (c == 5) begin
                chk("t6_owner_c5",  bus.Owner,  1);
                chk("t6_iready_c5", bus.IReady, 1);
            end
            tick();
        end
        rst = 0;

        // 7: randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) bus.IReq = ~bus.IReq;
            if ($urandom_range(0, 7) == 0) bus.DReq = ~bus.DReq;
            bus.IWE      = $urandom_range(0, 1);
            bus.DWE      = $urandom_range(0, 1);
            bus.IAddr    = $urandom;
            bus.DAddr    = $urandom;
            bus.IWData   = $urandom;
            bus.DWData   = $urandom;
            bus.MemRData = $urandom;
            bus.MemReady = ($urandom_range(0, 9) < 7);
            rst          = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;
        idle_inputs();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
